mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 185 ++++++++++++++++++
 tb/tb_mem_access.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-stage access unit: turns load/store requests into SRAM-like bus
// transactions, stalls the pipeline until the response, aligns/extends loads.
//   state | meaning
//   IDLE  | no transaction; latch fields on a valid access
//   REQ   | data_req high, waiting for data_addr_ok
//   WAIT  | address accepted, waiting for data_data_ok
//   DONE  | result held on load_data until the stage advances
module mem_access (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        mem_stall,
  input  logic        m_mem_re,
  input  logic        m_mem_we,
  input  logic        m_mem_sign_ext_flag,
  input  logic [3:0]  m_mem_sel,
  input  logic [31:0] m_mem_addr,
  input  logic [31:0] m_mem_wdata,
  input  logic [31:0] mem_exception_type,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        stallreq_mem,
  output logic [31:0] load_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        cancel_q, cancel_d;
  logic [31:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic        sext_q, sext_d;
  logic [31:0] rdata_q, rdata_d;

  logic        access_valid;
  logic        cancel_now;
  logic [1:0]  size_in;
  logic [31:0] wdata_in;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign access_valid = (m_mem_re | m_mem_we) & (mem_exception_type == 32'd0) & ~flush;
  // A flush arriving in the completing cycle still discards the result.
  assign cancel_now   = cancel_q | flush;

  always_comb begin
    size_in  = 2'd2;
    wdata_in = m_mem_wdata;
    case (m_mem_sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
        size_in  = 2'd0;
        wdata_in = {4{m_mem_wdata[7:0]}};
      end
      4'b0011, 4'b1100: begin
        size_in  = 2'd1;
        wdata_in = {2{m_mem_wdata[15:0]}};
      end
      default: begin
        size_in  = 2'd2;
        wdata_in = m_mem_wdata;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    size_d   = size_q;
    wdata_d  = wdata_q;
    sel_d    = sel_q;
    sext_d   = sext_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        cancel_d = 1'b0;
        if (access_valid) begin
          addr_d  = m_mem_addr;
          wr_d    = m_mem_we;
          size_d  = size_in;
          wdata_d = wdata_in;
          sel_d   = m_mem_sel;
          sext_d  = m_mem_sign_ext_flag;
          state_d = REQ;
        end
      end
      REQ: begin
        cancel_d = cancel_now;
        if (data_addr_ok && data_data_ok) begin
          if (cancel_now) begin
            state_d  = IDLE;
            cancel_d = 1'b0;
          end else begin
            rdata_d = data_rdata;
            state_d = DONE;
          end
        end else if (data_addr_ok) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cancel_d = cancel_now;
        if (data_data_ok) begin
          if (cancel_now) begin
            state_d  = IDLE;
            cancel_d = 1'b0;
          end else begin
            rdata_d = data_rdata;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (flush || !mem_stall) state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        cancel_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cancel_q <= 1'b0;
      addr_q   <= 32'd0;
      wr_q     <= 1'b0;
      size_q   <= 2'd0;
      wdata_q  <= 32'd0;
      sel_q    <= 4'd0;
      sext_q   <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      wdata_q  <= wdata_d;
      sel_q    <= sel_d;
      sext_q   <= sext_d;
      rdata_q  <= rdata_d;
    end
  end

  // Lane selection uses the sel latched with the request, not the live input.
  always_comb begin
    load_byte = rdata_q[7:0];
    load_half = rdata_q[15:0];
    load_data = rdata_q;
    case (sel_q)
      4'b0001: begin load_byte = rdata_q[7:0];   load_data = {{24{sext_q & load_byte[7]}}, load_byte}; end
      4'b0010: begin load_byte = rdata_q[15:8];  load_data = {{24{sext_q & load_byte[7]}}, load_byte}; end
      4'b0100: begin load_byte = rdata_q[23:16]; load_data = {{24{sext_q & load_byte[7]}}, load_byte}; end
      4'b1000: begin load_byte = rdata_q[31:24]; load_data = {{24{sext_q & load_byte[7]}}, load_byte}; end
      4'b0011: begin load_half = rdata_q[15:0];  load_data = {{16{sext_q & load_half[15]}}, load_half}; end
      4'b1100: begin load_half = rdata_q[31:16]; load_data = {{16{sext_q & load_half[15]}}, load_half}; end
      default: load_data = rdata_q;
    endcase
  end

  assign data_req     = (state_q == REQ);
  assign data_wr      = wr_q;
  assign data_size    = size_q;
  assign data_addr    = addr_q;
  assign data_wdata   = wdata_q;
  assign stallreq_mem = access_valid & (state_q != DONE);

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, same-cycle response,
// flush/cancel drain, exception suppression and reset behaviour.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush, mem_stall, m_mem_re, m_mem_we, m_mem_sign_ext_flag;
  logic [3:0]  m_mem_sel;
  logic [31:0] m_mem_addr, m_mem_wdata, mem_exception_type;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        stallreq_mem;
  logic [31:0] load_data;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access dut (
    .clk(clk), .reset(reset), .flush(flush), .mem_stall(mem_stall),
    .m_mem_re(m_mem_re), .m_mem_we(m_mem_we),
    .m_mem_sign_ext_flag(m_mem_sign_ext_flag), .m_mem_sel(m_mem_sel),
    .m_mem_addr(m_mem_addr), .m_mem_wdata(m_mem_wdata),
    .mem_exception_type(mem_exception_type),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .stallreq_mem(stallreq_mem),
    .load_data(load_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; mem_stall = 0; m_mem_re = 0; m_mem_we = 0; m_mem_sign_ext_flag = 0;
    m_mem_sel = 4'b0000; m_mem_addr = 0; m_mem_wdata = 0; mem_exception_type = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
  endtask

  // present an access in IDLE and move into REQ
  task automatic present(input logic re, input logic we, input logic [3:0] sel, input logic sx,
                         input logic [31:0] addr, input logic [31:0] wdata);
    m_mem_re = re; m_mem_we = we; m_mem_sel = sel; m_mem_sign_ext_flag = sx;
    m_mem_addr = addr; m_mem_wdata = wdata;
    cyc();
  endtask

  // from REQ: respond (same-cycle or one WAIT cycle later), end in DONE
  task automatic respond(input logic [31:0] rdata, input bit same);
    data_addr_ok = 1; data_data_ok = same; data_rdata = rdata;
    cyc();
    data_addr_ok = 0;
    if (!same) begin
      data_data_ok = 1;
      cyc();
    end
    data_data_ok = 0; data_rdata = 0;
  endtask

  // leave DONE with the stage advancing, then drop the request
  task automatic retire();
    mem_stall = 0;
    cyc();
    m_mem_re = 0; m_mem_we = 0;
    #1;
  endtask

  task automatic load_case(input string tag, input logic [3:0] sel, input logic sx,
                           input logic [31:0] rdata, input logic [31:0] exp);
    present(1, 0, sel, sx, 32'h0000_0040, 32'd0);
    respond(rdata, 0);
    #1;
    check(tag, load_data, exp);
    retire();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    #12;
    check("rst_req",    {31'd0, data_req}, 32'd0);
    check("rst_wr",     {31'd0, data_wr}, 32'd0);
    check("rst_size",   {30'd0, data_size}, 32'd0);
    check("rst_addr",   data_addr, 32'd0);
    check("rst_wdata",  data_wdata, 32'd0);
    check("rst_load",   load_data, 32'd0);
    check("rst_stall",  {31'd0, stallreq_mem}, 32'd0);
    reset = 0;
    cyc();

    // LW 0x100, addr_ok cycle 1, data_ok cycle 3
    m_mem_re = 1; m_mem_sel = 4'b1111; m_mem_addr = 32'h100; #1;
    check("lw_c0_stall", {31'd0, stallreq_mem}, 32'd1);
    check("lw_c0_req",   {31'd0, data_req}, 32'd0);
    cyc();
    data_addr_ok = 1; #1;
    check("lw_c1_req",   {31'd0, data_req}, 32'd1);
    check("lw_c1_addr",  data_addr, 32'h100);
    check("lw_c1_size",  {30'd0, data_size}, 32'd2);
    check("lw_c1_wr",    {31'd0, data_wr}, 32'd0);
    check("lw_c1_stall", {31'd0, stallreq_mem}, 32'd1);
    cyc();
    data_addr_ok = 0; #1;
    check("lw_c2_req",   {31'd0, data_req}, 32'd0);
    check("lw_c2_stall", {31'd0, stallreq_mem}, 32'd1);
    cyc();
    data_data_ok = 1; data_rdata = 32'h89AB_CDEF; #1;
    check("lw_c3_stall", {31'd0, stallreq_mem}, 32'd1);
    cyc();
    data_data_ok = 0; data_rdata = 0; #1;
    check("lw_c4_stall", {31'd0, stallreq_mem}, 32'd0);
    check("lw_c4_load",  load_data, 32'h89AB_CDEF);
    retire();

    // load alignment / extension
    load_case("lb_sx",  4'b0100, 1, 32'h00F3_0000, 32'hFFFF_FFF3);
    load_case("lbu",    4'b0100, 0, 32'h00F3_0000, 32'h0000_00F3);
    load_case("lhu_hi", 4'b1100, 0, 32'h8001_1234, 32'h0000_8001);
    load_case("lh_lo",  4'b0011, 1, 32'h1234_8001, 32'hFFFF_8001);
    load_case("lb_b3",  4'b1000, 1, 32'h7F00_00FF, 32'h0000_007F);

    // stores
    present(0, 1, 4'b0010, 0, 32'h0000_0201, 32'h0000_00A5);
    check("sb_wr",    {31'd0, data_wr}, 32'd1);
    check("sb_size",  {30'd0, data_size}, 32'd0);
    check("sb_wdata", data_wdata, 32'hA5A5_A5A5);
    respond(32'd0, 1);
    retire();
    present(1, 1, 4'b1100, 0, 32'h0000_0302, 32'h1234_BEEF);
    check("sh_wr",    {31'd0, data_wr}, 32'd1);
    check("sh_size",  {30'd0, data_size}, 32'd1);
    check("sh_wdata", data_wdata, 32'hBEEF_BEEF);
    respond(32'd0, 0);
    retire();

    // addr_ok and data_ok in the same cycle: REQ -> DONE
    present(1, 0, 4'b1111, 0, 32'h0000_0400, 32'd0);
    data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h1357_9BDF;
    cyc();
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0; #1;
    check("same_stall", {31'd0, stallreq_mem}, 32'd0);
    check("same_load",  load_data, 32'h1357_9BDF);
    retire();

    // flush during WAIT, new LW presented while the stale response drains
    present(1, 0, 4'b1111, 0, 32'h0000_0200, 32'd0);
    data_addr_ok = 1;
    cyc();
    data_addr_ok = 0; flush = 1; m_mem_re = 0;
    cyc();
    flush = 0; m_mem_re = 1; m_mem_addr = 32'h0000_0300; #1;
    check("fl_w_stall", {31'd0, stallreq_mem}, 32'd1);
    check("fl_w_req",   {31'd0, data_req}, 32'd0);
    cyc();
    data_data_ok = 1; data_rdata = 32'hDEAD_BEEF; #1;
    check("fl_ok_req",   {31'd0, data_req}, 32'd0);
    check("fl_ok_stall", {31'd0, stallreq_mem}, 32'd1);
    cyc();
    data_data_ok = 0; data_rdata = 0; #1;
    check("fl_idle_req",   {31'd0, data_req}, 32'd0);
    check("fl_idle_stall", {31'd0, stallreq_mem}, 32'd1);
    check("fl_idle_load",  load_data, 32'h1357_9BDF);
    cyc();
    check("fl_new_req",  {31'd0, data_req}, 32'd1);
    check("fl_new_addr", data_addr, 32'h0000_0300);
    respond(32'h2468_ACE0, 1);
    #1;
    check("fl_new_load", load_data, 32'h2468_ACE0);
    retire();

    // exception suppresses the access; flush in IDLE starts nothing
    m_mem_re = 1; m_mem_sel = 4'b1111; mem_exception_type = 32'h0000_0004; #1;
    check("exc_stall", {31'd0, stallreq_mem}, 32'd0);
    cyc();
    check("exc_req", {31'd0, data_req}, 32'd0);
    mem_exception_type = 0; flush = 1; #1;
    check("fl_i_stall", {31'd0, stallreq_mem}, 32'd0);
    cyc();
    check("fl_i_req", {31'd0, data_req}, 32'd0);
    flush = 0; m_mem_re = 0; #1;

    // DONE held under mem_stall, flush returns to IDLE
    mem_stall = 1;
    present(1, 0, 4'b0001, 1, 32'h0000_0500, 32'd0);
    respond(32'h0000_0080, 0);
    cyc();
    check("hold_req",   {31'd0, data_req}, 32'd0);
    check("hold_stall", {31'd0, stallreq_mem}, 32'd0);
    check("hold_load",  load_data, 32'hFFFF_FF80);
    flush = 1;
    cyc();
    flush = 0; #1;
    check("fl_d_idle", {31'd0, stallreq_mem}, 32'd1);
    m_mem_re = 0; mem_stall = 0; #1;

    // reset during REQ drops data_req asynchronously; nothing afterwards
    present(1, 0, 4'b1111, 0, 32'h0000_0600, 32'd0);
    check("rq_req", {31'd0, data_req}, 32'd1);
    reset = 1; #1;
    check("rq_rst_req",  {31'd0, data_req}, 32'd0);
    check("rq_rst_addr", data_addr, 32'd0);
    m_mem_re = 0;
    cyc();
    reset = 0;
    data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'hCAFE_F00D;
    cyc();
    cyc();
    data_addr_ok = 0; data_data_ok = 0; #1;
    check("rq_post_req",  {31'd0, data_req}, 32'd0);
    check("rq_post_load", load_data, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
